// File: rtl/axi4_switch_rr_n1.sv
// N:1 AXI4-Stream packet switch with packet-atomic round-robin arbitration,
// per-port request suppression, a 2-entry output buffer, source ID and packet counter.
module axi4_switch_rr_n1 #(
    parameter  int NUM_S   = 3,
    parameter  int TDATA_L = 512,
    parameter  int TUSER_L = 81,
    parameter  int TKEEP_L = 16,
    parameter  int CNT_W   = 16,
    localparam int SEL_W   = $clog2(NUM_S)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_S-1:0]           s_req_supress,
    input  logic [NUM_S*TDATA_L-1:0]   s_tdata_i,
    input  logic [NUM_S*TUSER_L-1:0]   s_tuser_i,
    input  logic [NUM_S*TKEEP_L-1:0]   s_tkeep_i,
    input  logic [NUM_S-1:0]           s_tlast_i,
    input  logic [NUM_S-1:0]           s_tvalid_i,
    output logic [NUM_S-1:0]           s_tready_o,
    output logic [TDATA_L-1:0]         m_tdata_o,
    output logic [TUSER_L-1:0]         m_tuser_o,
    output logic [TKEEP_L-1:0]         m_tkeep_o,
    output logic                       m_tlast_o,
    output logic [SEL_W-1:0]           m_tid_o,
    output logic                       m_tvalid_o,
    input  logic                       m_tready_i,
    output logic [SEL_W-1:0]           grant_o,
    output logic                       busy_o,
    output logic [CNT_W-1:0]           pkt_cnt_o
);

    // Handshake: a beat moves on a port at a rising edge where valid and ready
    // are both 1; ready never depends combinationally on valid or m_tready_i.
    localparam int EW = SEL_W + 1 + TKEEP_L + TUSER_L + TDATA_L;
    localparam logic [NUM_S-1:0] ONE       = NUM_S'(1);
    localparam logic [SEL_W-1:0] LAST_PORT = SEL_W'(NUM_S - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [SEL_W-1:0] ptr, grant, winner;
    logic             found;
    logic [NUM_S-1:0] req, ready;
    logic [EW-1:0]    mem0, mem1, in_entry, head;
    logic             wr_ptr, rd_ptr;
    logic [1:0]       count, count_nxt;
    logic             push, pop, in_last;
    logic [CNT_W-1:0] pkt_cnt;
    int               gi, idx;

    // Round-robin scan starting at ptr, wrapping at NUM_S-1.
    always_comb begin
        req    = s_tvalid_i & ~s_req_supress;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NUM_S; i++) begin
            idx = (int'(ptr) + i) % NUM_S;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = SEL_W'(idx);
            end
        end
    end

    always_comb begin
        gi       = int'(grant);
        in_last  = s_tlast_i[grant];
        in_entry = {grant, s_tlast_i[grant], s_tkeep_i[gi*TKEEP_L +: TKEEP_L],
                    s_tuser_i[gi*TUSER_L +: TUSER_L], s_tdata_i[gi*TDATA_L +: TDATA_L]};
        push     = (state == BUSY) && s_tvalid_i[grant] && ready[grant];
        head     = rd_ptr ? mem1 : mem0;
        pop      = (count != 2'd0) && m_tready_i;
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 2'd1;
        else if (!push && pop)
            count_nxt = count - 2'd1;
    end

    // Ready is registered from the post-edge occupancy so a full buffer never overflows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            grant   <= '0;
            ready   <= '0;
            mem0    <= '0;
            mem1    <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            pkt_cnt <= '0;
        end else begin
            if (push) begin
                if (wr_ptr)
                    mem1 <= in_entry;
                else
                    mem0 <= in_entry;
                wr_ptr <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count_nxt;
            if (pop && m_tlast_o)
                pkt_cnt <= pkt_cnt + CNT_W'(1);
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= BUSY;
                        grant <= winner;
                        ready <= (count_nxt < 2'd2) ? (ONE << winner) : '0;
                    end
                end
                BUSY: begin
                    if (push && in_last) begin
                        state <= IDLE;
                        ptr   <= (grant == LAST_PORT) ? '0 : grant + SEL_W'(1);
                        ready <= '0;
                    end else begin
                        ready <= (count_nxt < 2'd2) ? (ONE << grant) : '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign {m_tid_o, m_tlast_o, m_tkeep_o, m_tuser_o, m_tdata_o} = head;
    assign m_tvalid_o = (count != 2'd0);
    assign s_tready_o = ready;
    assign grant_o    = grant;
    assign busy_o     = (state == BUSY);
    assign pkt_cnt_o  = pkt_cnt;

endmodule
